mod_add_sequencer: RTL and testbench



---
 rtl/mod_add_sequencer.sv | 143 ++++++++++++++
 tb/tb_mod_add_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mod_add_sequencer.sv
// Modular adder for the RSA datapath: r = (a + b) mod n.
// One shared ripple-carry adder is used twice: first for a + b, then
// for s - n (as s + ~n + 1). The carries of both passes pick the result.

// Plain WIDTH-bit ripple-carry adder, built one full-adder per bit.
module mod_add_rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] carry;

  assign carry[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign s[gi]         = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi + 1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign co = carry[WIDTH];

endmodule

module mod_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH-1:0] add_sum;
  logic             add_co;

  // Adder operand mux: SUB computes s - n, every other state feeds a + b.
  always_comb begin
    add_x  = a_reg;
    add_y  = b_reg;
    add_ci = 1'b0;
    if (state_reg == S_SUB) begin
      add_x  = s_reg;
      add_y  = ~n_reg;
      add_ci = 1'b1;
    end
  end

  mod_add_rca #(
    .WIDTH(WIDTH)
  ) u_rca (
    .x (add_x),
    .y (add_y),
    .ci(add_ci),
    .s (add_sum),
    .co(add_co)
  );

  // Sequencer: accept in IDLE/DONE, two adder passes, one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      n_reg      <= '0;
      s_reg      <= '0;
      c_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_ADD: begin
          s_reg     <= add_sum;
          c_reg     <= add_co;
          state_reg <= S_SUB;
        end
        S_SUB: begin
          // True sum >= n when pass 1 overflowed or pass 2 did not borrow.
          if (c_reg | add_co) begin
            result_reg <= add_sum;
          end else begin
            result_reg <= s_reg;
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_DONE;
        end
        default: begin
          // IDLE and DONE both accept a new request.
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            n_reg     <= n;
            busy_reg  <= 1'b1;
            state_reg <= S_ADD;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_mod_add_sequencer.sv
// Testbench for mod_add_sequencer: WIDTH=8 and WIDTH=16 instances share
// clock, reset and start; a cycle-level model predicts busy/done/result.
module tb_mod_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a8, b8, n8;
  logic [15:0] a16, b16, n16;
  logic        busy8, done8, busy16, done16;
  logic [7:0]  result8;
  logic [15:0] result16;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: cycles since accept (0 idle, 1 add, 2 sub, 3 done).
  int ph8 = 0, pend8 = 0, res8 = 0;
  int ph16 = 0, pend16 = 0, res16 = 0;

  always #5 clk = ~clk;

  mod_add_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a8), .b(b8), .n(n8),
    .busy(busy8), .done(done8), .result(result8)
  );

  mod_add_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a16), .b(b16), .n(n16),
    .busy(busy16), .done(done16), .result(result16)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result is (a+b) mod n, valid 3 cycles after accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph8 <= 0; res8 <= 0; ph16 <= 0; res16 <= 0;
    end else begin
      if (ph8 == 1) ph8 <= 2;
      else if (ph8 == 2) begin ph8 <= 3; res8 <= pend8; end
      else if (start) begin
        ph8   <= 1;
        pend8 <= (int'(a8) + int'(b8)) % int'(n8);
      end else ph8 <= 0;

      if (ph16 == 1) ph16 <= 2;
      else if (ph16 == 2) begin ph16 <= 3; res16 <= pend16; end
      else if (start) begin
        ph16   <= 1;
        pend16 <= (int'(a16) + int'(b16)) % int'(n16);
      end else ph16 <= 0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8",    longint'(busy8),    longint'(ph8 == 1 || ph8 == 2));
      chk("done8",    longint'(done8),    longint'(ph8 == 3));
      chk("result8",  longint'(result8),  longint'(res8));
      chk("busy16",   longint'(busy16),   longint'(ph16 == 1 || ph16 == 2));
      chk("done16",   longint'(done16),   longint'(ph16 == 3));
      chk("result16", longint'(result16), longint'(res16));
    end
  end

  // Waits (bounded) for done8; returns number of negedges waited.
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc++;
      if (done8) return;
    end
    errors++;
    checks++;
    $display("FAIL %s: done timeout got none expected pulse", name);
  endtask

  // One directed WIDTH=8 operation with a hand-computed expected result.
  task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic [7:0] tn, input int exp);
    int cyc;
    @(negedge clk);
    a8 = ta; b8 = tb_; n8 = tn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a8 = 8'hff; b8 = 8'hff; n8 = 8'h01;
    chk({name, "_busy"}, longint'(busy8), 1);
    wait_done(name, cyc);
    chk({name, "_lat"}, longint'(cyc), 2);
    chk({name, "_res"}, longint'(result8), longint'(exp));
    $display("op %s a=%0d b=%0d n=%0d result=%0d", name, ta, tb_, tn, result8);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0;
    a8 = '0; b8 = '0; n8 = 8'd1;
    a16 = '0; b16 = '0; n16 = 16'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   longint'(busy8),   0);
    chk("rst_done",   longint'(done8),   0);
    chk("rst_result", longint'(result8), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run8("basic",   8'd10,  8'd20,  8'd251, 30);
    run8("carry",   8'd200, 8'd100, 8'd251, 49);
    run8("max",     8'd250, 8'd250, 8'd251, 249);
    run8("eq_n",    8'd125, 8'd126, 8'd251, 0);

    // Back-to-back with start held high; start during ADD/SUB must be ignored.
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd2; n8 = 8'd7; start = 1'b1;
    @(negedge clk);  // ADD
    a8 = 8'd5; b8 = 8'd6;
    @(negedge clk);  // SUB
    chk("b2b_hold0", longint'(result8), 0);
    @(negedge clk);  // DONE of first
    chk("b2b_done1", longint'(done8), 1);
    chk("b2b_res1",  longint'(result8), 3);
    $display("op b2b1 a=1 b=2 n=7 result=%0d", result8);
    @(negedge clk);  // ADD of second
    a8 = 8'd0; b8 = 8'd0;
    chk("b2b_hold1", longint'(result8), 3);
    @(negedge clk);  // SUB of second
    chk("b2b_hold2", longint'(result8), 3);
    @(negedge clk);  // DONE of second, 3 cycles after the first
    start = 1'b0;
    chk("b2b_done2", longint'(done8), 1);
    chk("b2b_res2",  longint'(result8), 4);
    $display("op b2b2 a=5 b=6 n=7 result=%0d", result8);

    // Reset during SUB aborts with no later done pulse.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; n8 = 8'd251; start = 1'b1;
    @(negedge clk);  // ADD
    start = 1'b0;
    @(negedge clk);  // SUB
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy",   longint'(busy8),   0);
    chk("abort_done",   longint'(done8),   0);
    chk("abort_result", longint'(result8), 0);
    $display("op abort a=200 b=100 n=251 result=%0d", result8);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_nodone", longint'(done8), 0);
    end
    run8("post_rst", 8'd200, 8'd100, 8'd251, 49);

    // Random trials on both widths; the compare process checks each cycle.
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      n8  = 8'($urandom_range(255, 1));
      a8  = 8'($urandom_range(int'(n8) - 1, 0));
      b8  = 8'($urandom_range(int'(n8) - 1, 0));
      n16 = 16'($urandom_range(65535, 1));
      a16 = 16'($urandom_range(int'(n16) - 1, 0));
      b16 = 16'($urandom_range(int'(n16) - 1, 0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("rand", cyc);
      $display("op rand%0d w8 result=%0d w16 result=%0d", t, result8, result16);
      a8 = 8'($urandom); b8 = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
